mem_burst_responder: RTL and testbench

- Main-memory responder on the far end of the CPU's instruction and data memory interface.
- Accepts one request at a time from the fetch, memory, or cache-fill side:
  - single-word read;
  - single-word write;
  - 8-word line burst read.
- Answers after a fixed access latency. Models the multi-cycle main memory that the pipeline's stall logic is built around.
- Holds the backing store internally.

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_burst_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_burst_responder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and default constants for the main-memory burst responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int DEF_LATENCY   = 4;
    localparam int DEF_BURST_LEN = 8;
    localparam int WORD_W        = 16;

endpackage

// File: rtl/mem_array.sv
// Word-addressed backing store: synchronous write, asynchronous read, no reset.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_W = 15
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DEPTH_W-1:0]  waddr,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [DEPTH_W-1:0]  raddr,
    output logic [WORD_W-1:0]   rdata
);

    logic [WORD_W-1:0] mem [0:(1<<DEPTH_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_burst_responder.sv
// Fixed-latency main-memory responder: single read, single write, line burst read.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | access latency countdown; acts on the captured request at cnt==0
//   XFER  | streaming burst beats 1..BURST_LEN-1
module mem_burst_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DEPTH_W   = 15,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic [2:0]        rsp_idx,
    output logic              rsp_last,
    output logic              wr_ack,
    output logic              busy
);

    localparam int         BEAT_W    = $clog2(BURST_LEN);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

    state_t              state, next_state;
    logic [3:0]          cnt;
    logic [2:0]          beat;
    logic [ADDR_W-1:0]   cap_addr;
    logic                cap_we;
    logic                cap_burst;
    logic [15:0]         cap_wdata;

    logic                accept;
    logic                mem_we;
    logic [DEPTH_W-1:0]  word_idx;
    logic [DEPTH_W-1:0]  raddr;
    logic [WORD_W-1:0]   rdata;

    logic                rsp_valid_d;
    logic                rsp_last_d;
    logic                wr_ack_d;
    logic [2:0]          rsp_idx_d;
    logic [15:0]         rsp_data_d;

    logic                unused_addr_bits;
    assign unused_addr_bits = ^{cap_addr[ADDR_W-1:DEPTH_W+1], cap_addr[0]};

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // Bursts stay inside their line: upper index bits from the address, low bits from the beat.
    assign word_idx = cap_addr[DEPTH_W:1];
    assign raddr    = cap_burst ? {cap_addr[DEPTH_W:BEAT_W+1], beat[BEAT_W-1:0]} : word_idx;

    mem_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx),
        .wdata (cap_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = (cap_burst && !cap_we) ? XFER : IDLE;
                end
            end
            XFER: begin
                if (beat == LAST_BEAT) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Beat 0 of a burst is emitted on the WAIT->XFER edge so the first word
    // lands exactly LATENCY cycles after accept.
    always_comb begin
        mem_we      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        wr_ack_d    = 1'b0;
        rsp_idx_d   = rsp_idx;
        rsp_data_d  = rsp_data;
        case (state)
            WAIT: begin
                if (cnt == 4'd0) begin
                    if (cap_we) begin
                        mem_we   = !rst;
                        wr_ack_d = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rdata;
                        rsp_idx_d   = 3'd0;
                        rsp_last_d  = !cap_burst;
                    end
                end
            end
            XFER: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rdata;
                rsp_idx_d   = beat;
                rsp_last_d  = (beat == LAST_BEAT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            wr_ack    <= 1'b0;
            rsp_idx   <= 3'd0;
            rsp_data  <= 16'd0;
        end else begin
            rsp_valid <= rsp_valid_d;
            rsp_last  <= rsp_last_d;
            wr_ack    <= wr_ack_d;
            rsp_idx   <= rsp_idx_d;
            rsp_data  <= rsp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            beat      <= 3'd0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_burst <= 1'b0;
            cap_wdata <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr  <= req_addr;
                        cap_we    <= req_we;
                        cap_burst <= req_burst && !req_we;
                        cap_wdata <= req_wdata;
                        cnt       <= CNT_LOAD;
                        beat      <= 3'd0;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (cap_burst && !cap_we) begin
                        beat <= 3'd1;
                    end
                end
                XFER: begin
                    beat <= (beat == LAST_BEAT) ? 3'd0 : beat + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder against a word-array reference model.
module tb_mem_burst_responder;

    localparam int LAT   = 4;
    localparam int BL    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << DW;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_burst;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_idx;
    logic        rsp_last;
    logic        wr_ack;
    logic        busy;

    logic [15:0] model_mem [DEPTH];
    int total = 0;
    int bad   = 0;

    mem_burst_responder #(
        .ADDR_W    (16),
        .DEPTH_W   (DW),
        .LATENCY   (LAT),
        .BURST_LEN (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_burst (req_burst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_idx   (rsp_idx),
        .rsp_last  (rsp_last),
        .wr_ack    (wr_ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    function automatic int bidx(input logic [15:0] a, input int b);
        return (((int'(a) / 2) / BL) * BL + b) % DEPTH;
    endfunction

    // Presents one request and returns just after the accepting edge.
    task automatic send(input logic we, input logic burst, input logic [15:0] addr,
                        input logic [15:0] wdata, output int waits);
        @(negedge clk);
        req_we    = we;
        req_burst = burst;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        waits     = 0;
        while (!req_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic read_word(input logic [15:0] addr, output logic [15:0] data,
                             output logic [2:0] idx, output logic last, output int lat);
        int waits;
        send(1'b0, 1'b0, addr, 16'h0, waits);
        lat = -1;
        data = 'x; idx = 'x; last = 'x;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (rsp_valid && lat < 0) begin
                lat = k; data = rsp_data; idx = rsp_idx; last = rsp_last;
            end
        end
    endtask

    task automatic write_word(input logic [15:0] addr, input logic [15:0] data, output int lat);
        int waits;
        send(1'b1, 1'b0, addr, data, waits);
        lat = -1;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (wr_ack && lat < 0) lat = k;
        end
        if (lat == LAT) model_mem[widx(addr)] = data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL rst_ready_low got=%b want=0", req_ready);
        end
        total++;
        if ({rsp_valid, rsp_last, wr_ack, busy, rsp_idx, rsp_data} !== 23'd0) begin
            bad++;
            $display("FAIL rst_outputs got v=%b l=%b a=%b b=%b idx=%0d d=%h want all 0",
                     rsp_valid, rsp_last, wr_ack, busy, rsp_idx, rsp_data);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++;
            if ({req_ready, busy, rsp_valid, wr_ack} !== 4'b1000) begin
                bad++;
                $display("FAIL idle_cycle%0d got rdy=%b busy=%b v=%b ack=%b want rdy=1 others 0",
                         k, req_ready, busy, rsp_valid, wr_ack);
            end
        end
    endtask

    task automatic test_fill;
        int lat;
        logic [15:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            a = 16'((i * 2) | ($urandom_range(0, 3) << 5));
            write_word(a, 16'($urandom), lat);
            total++;
            if (lat !== LAT) begin
                bad++; $display("FAIL fill_ack_lat idx=%0d got=%0d want=%0d", i, lat, LAT);
            end
        end
    endtask

    task automatic test_write_read;
        int lat;
        logic [15:0] d;
        logic [2:0]  idx;
        logic        last;
        write_word(16'h0010, 16'hBEEF, lat);
        total++;
        if (lat !== LAT) begin
            bad++; $display("FAIL wr_ack_lat got=%0d want=%0d", lat, LAT);
        end
        read_word(16'h0010, d, idx, last, lat);
        total++;
        if (lat !== LAT) begin
            bad++; $display("FAIL rd_lat got=%0d want=%0d", lat, LAT);
        end
        total++;
        if ({d, idx, last} !== {16'hBEEF, 3'd0, 1'b1}) begin
            bad++; $display("FAIL rd_word got d=%h idx=%0d last=%b want d=beef idx=0 last=1", d, idx, last);
        end
    endtask

    task automatic test_burst;
        int lat;
        int waits;
        int beats;
        for (int i = 0; i < BL; i++) begin
            write_word(16'(16'h0020 + 2 * i), 16'(16'h1000 + i), lat);
        end
        send(1'b0, 1'b1, 16'h0026, 16'h0, waits);
        total++;
        if (waits !== 0) begin
            bad++; $display("FAIL burst_accept got waits=%0d want=0", waits);
        end
        beats = 0;
        for (int k = 1; k <= LAT + BL + 2; k++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== (k >= LAT && k < LAT + BL)) begin
                bad++; $display("FAIL burst_valid k=%0d got=%b", k, rsp_valid);
            end
            if (rsp_valid) begin
                total++;
                if ({rsp_data, rsp_idx, rsp_last} !==
                    {16'(16'h1000 + k - LAT), 3'(k - LAT), 1'(k == LAT + BL - 1)}) begin
                    bad++;
                    $display("FAIL burst_beat k=%0d got d=%h idx=%0d last=%b want d=%h idx=%0d last=%b",
                             k, rsp_data, rsp_idx, rsp_last, 16'(16'h1000 + k - LAT), k - LAT,
                             (k == LAT + BL - 1));
                end
                beats++;
            end
        end
        total++;
        if (beats !== BL) begin
            bad++; $display("FAIL burst_count got=%0d want=%0d", beats, BL);
        end
    endtask

    task automatic test_backpressure;
        int waits;
        int seen_last;
        int hits;
        logic [15:0] b_addr;
        b_addr = 16'($urandom);
        send(1'b0, 1'b1, 16'($urandom), 16'h0, waits);
        req_we = 1'b0; req_burst = 1'b0; req_addr = b_addr; req_valid = 1'b1;
        seen_last = -1;
        for (int k = 1; k <= LAT + BL + 4 && seen_last < 0; k++) begin
            @(posedge clk); #1;
            if (rsp_valid && rsp_last) begin
                seen_last = k;
                total++;
                if (req_ready !== 1'b1) begin
                    bad++; $display("FAIL bp_ready_at_last got=%b want=1", req_ready);
                end
            end else begin
                total++;
                if (req_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_ready_during k=%0d got=%b want=0", k, req_ready);
                end
            end
        end
        total++;
        if (seen_last !== LAT + BL - 1) begin
            bad++; $display("FAIL bp_last_cycle got=%0d want=%0d", seen_last, LAT + BL - 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        hits = 0;
        for (int k = 1; k <= 2 * LAT + 4; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                hits++;
                total++;
                if ({rsp_data, k} !== {model_mem[widx(b_addr)], LAT}) begin
                    bad++; $display("FAIL bp_queued_read k=%0d got d=%h want d=%h at k=%0d",
                                    k, rsp_data, model_mem[widx(b_addr)], LAT);
                end
            end
        end
        total++;
        if (hits !== 1) begin
            bad++; $display("FAIL bp_accept_count got=%0d want=1", hits);
        end
    endtask

    task automatic test_rst_mid;
        int waits;
        int lat;
        logic [15:0] a;
        logic [15:0] d;
        logic [2:0]  idx;
        logic        last;
        send(1'b0, 1'b1, 16'($urandom), 16'h0, waits);
        repeat (LAT + 3) begin
            @(posedge clk); #1;
        end
        total++;
        if ({rsp_valid, rsp_idx} !== {1'b1, 3'd3}) begin
            bad++; $display("FAIL rst_burst_beat3 got v=%b idx=%0d want v=1 idx=3", rsp_valid, rsp_idx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, wr_ack, busy} !== 3'b000) begin
            bad++; $display("FAIL rst_burst_abort got v=%b ack=%b busy=%b want 000", rsp_valid, wr_ack, busy);
        end
        rst = 1'b0;
        a = 16'($urandom);
        send(1'b1, 1'b0, a, ~model_mem[widx(a)], waits);
        repeat (LAT - 2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, wr_ack, busy} !== 3'b000) begin
            bad++; $display("FAIL rst_write_abort got v=%b ack=%b busy=%b want 000", rsp_valid, wr_ack, busy);
        end
        rst = 1'b0;
        read_word(a, d, idx, last, lat);
        total++;
        if ({d, lat} !== {model_mem[widx(a)], LAT}) begin
            bad++; $display("FAIL rst_write_discard got d=%h lat=%0d want d=%h lat=%0d",
                            d, lat, model_mem[widx(a)], LAT);
        end
    endtask

    task automatic test_alias;
        int lat;
        logic [15:0] d;
        logic [2:0]  idx;
        logic        last;
        write_word(16'h0002, 16'hAAAA, lat);
        read_word(16'h0022, d, idx, last, lat);
        total++;
        if (d !== 16'hAAAA) begin
            bad++; $display("FAIL alias_read got=%h want=aaaa", d);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int waits;
        logic [15:0] a;
        logic [15:0] wd;
        a  = 16'($urandom);
        wd = 16'($urandom);
        send(1'b1, 1'b0, a, wd, waits);
        repeat (LAT) begin
            @(posedge clk); #1;
        end
        total++;
        if (wr_ack !== 1'b1) begin
            bad++; $display("FAIL b2b_ack got=%b want=1", wr_ack);
        end
        model_mem[widx(a)] = wd;
        send(1'b0, 1'b0, a, 16'h0, waits);
        total++;
        if (waits !== 0) begin
            bad++; $display("FAIL b2b_accept got waits=%0d want=0", waits);
        end
        lat = -1;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(posedge clk); #1;
            if (rsp_valid && lat < 0) begin
                lat = k;
                total++;
                if (rsp_data !== wd) begin
                    bad++; $display("FAIL b2b_data got=%h want=%h", rsp_data, wd);
                end
            end
        end
        total++;
        if (lat !== LAT) begin
            bad++; $display("FAIL b2b_lat got=%0d want=%0d", lat, LAT);
        end
    endtask

    task automatic test_random;
        int waits;
        int kind;
        int span;
        logic [15:0] a;
        logic [15:0] wd;
        logic        exp_v;
        logic        exp_a;
        logic [15:0] exp_d;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            a    = 16'($urandom);
            wd   = 16'($urandom);
            // kind 3 is a write that also raises req_burst, which must be ignored.
            send(kind == 0 || kind == 3, kind >= 2, a, wd, waits);
            span = (kind == 2) ? BL : 1;
            for (int k = 1; k <= LAT + BL + 1; k++) begin
                @(posedge clk); #1;
                exp_a = (kind == 0 || kind == 3) && (k == LAT);
                exp_v = (kind == 1 || kind == 2) && (k >= LAT) && (k < LAT + span);
                total++;
                if ({rsp_valid, wr_ack} !== {exp_v, exp_a}) begin
                    bad++; $display("FAIL rnd%0d_kind%0d_k%0d got v=%b ack=%b want v=%b ack=%b",
                                    t, kind, k, rsp_valid, wr_ack, exp_v, exp_a);
                end
                if (exp_v && rsp_valid) begin
                    exp_d = (kind == 2) ? model_mem[bidx(a, k - LAT)] : model_mem[widx(a)];
                    total++;
                    if ({rsp_data, rsp_idx, rsp_last} !==
                        {exp_d, 3'(k - LAT), 1'(k == LAT + span - 1)}) begin
                        bad++;
                        $display("FAIL rnd%0d_data k=%0d got d=%h idx=%0d last=%b want d=%h idx=%0d last=%b",
                                 t, k, rsp_data, rsp_idx, rsp_last, exp_d, k - LAT, (k == LAT + span - 1));
                    end
                end
            end
            if (kind == 0 || kind == 3) model_mem[widx(a)] = wd;
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_write_read;
        test_burst;
        test_backpressure;
        test_rst_mid;
        test_alias;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
